ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, the RAM word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 7, the RAM address width; depth = 2^AWIDTH.
REQ-003 SHALL have port clk  input  1  the single clock for all logic and for the RAM read port.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  AWIDTH  first RAM address, captured on the accepted start.
REQ-007 SHALL have port length  input  AWIDTH+1  word count (0..2^AWIDTH), captured on the accepted start.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last word handshakes.
REQ-010 SHALL have port rden  output  1  RAM read enable.
REQ-011 SHALL have port rdaddr  output  AWIDTH  RAM read address.
REQ-012 SHALL have port rd_data  input  DWIDTH  RAM registered read data, valid one cycle after rden.
REQ-013 SHALL have ports m_data (output, DWIDTH), m_valid (output, 1), m_ready (input, 1) and m_last (output, 1), forming the output stream.

Function
REQ-014 FSM SHALL have exactly three states:
- IDLE: start=1 and length>0 -> READ.
- READ: last read issued -> DRAIN.
- DRAIN: last word handshakes -> IDLE, done=1 for one cycle.
REQ-015 start=1 with length=0 in IDLE SHALL pulse done on the next cycle without issuing any read and without leaving IDLE.
REQ-016 Reads SHALL use addresses base_addr, base_addr+1, …, incremented modulo 2^AWIDTH, so a burst wraps from 2^AWIDTH-1 to 0.
REQ-017 The block SHALL hold a 2-entry output buffer and SHALL assert rden only when (occupancy + reads in flight) < 2.
- The buffer never overflows.
- No word is dropped or duplicated under any m_ready pattern.
REQ-018 Without backpressure, first m_valid SHALL occur 2 cycles after start is accepted, with one word per cycle thereafter.
REQ-019 Stream handshake rules:
- A word transfers when m_valid and m_ready are both high.
- m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0.
- m_valid SHALL not deassert without a transfer.
REQ-020 m_last SHALL be high only with the length-th word of the burst.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 A full burst with length=2^AWIDTH SHALL read every address exactly once.

Reset
REQ-023 rst_n low SHALL immediately force:
- state to IDLE;
- busy, done, rden, m_valid and m_last to 0;
- rdaddr and m_data to 0;
- buffer empty and in-flight count 0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst with no done pulse; the first cycle after deassertion behaves as IDLE.

Configuration
REQ-025 With macro RAM_READER_CSUM_EN defined, the block SHALL add outputs csum (DWIDTH) and csum_valid (1).
- csum is the XOR of all words transferred in the burst.
- csum_valid pulses with done.
- csum resets to 0 and clears on each accepted start.
- For length=0, csum=0.
REQ-026 Without RAM_READER_CSUM_EN, those ports and their logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-027 Package ram_reader_pkg SHALL hold the FSM state encoding (IDLE=0, READ=1, DRAIN=2) and the buffer depth constant (2).
REQ-028 The 2-entry output buffer SHALL be a sub-module named ram_reader_skid, with push, pop, full, empty and count.

Verification
REQ-029 RAM preloaded with word k = 0x1000+k; base=3, length=4, m_ready=1 -> m_data 0x1003..0x1006 on consecutive cycles, m_last on 0x1006, done one cycle later.
REQ-030 base=126, length=4, AWIDTH=7 -> addresses 126, 127, 0, 1; data 0x107E, 0x107F, 0x1000, 0x1001.
REQ-031 length=8 with m_ready toggling 1,0,0,1 repeating -> exactly 8 ordered words, data stable while stalled, and rden never leaves more than 2 words outstanding.
REQ-032 start with length=0 -> no rden and no m_valid, done one cycle later; with CSUM_EN, csum=0.
REQ-033 rst_n pulsed low after 3 of 10 words -> all outputs 0 immediately, no done, and a new start then runs correctly.
REQ-034 CSUM_EN, words 0xAAAA, 0x5555, 0x00FF -> csum=0xFF00 with csum_valid coincident with done.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// ram_reader shared types: FSM encoding and output buffer depth.
// Optional checksum outputs are enabled by defining RAM_READER_CSUM_EN.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ram_reader_skid.sv
// Two-entry output buffer for ram_reader; holds data plus last flag.
module ram_reader_skid
  import ram_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wptr;
  logic         rptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'(BUF_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ram_reader.sv
// Burst reader: streams length words from a registered-read RAM.
// Define RAM_READER_CSUM_EN to add the csum/csum_valid outputs.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic              rden,
  output logic [AWIDTH-1:0] rdaddr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef RAM_READER_CSUM_EN
  ,
  output logic [DWIDTH-1:0] csum,
  output logic              csum_valid
`endif
);

  state_t            state;
  logic [AWIDTH:0]   rem;
  logic              pend;
  logic              pend_last;
  logic              pop;
  logic              fin;
  logic              full;
  logic              empty;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic [DWIDTH:0]   head;

  ram_reader_skid #(.W(DWIDTH + 1)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend),
    .pop   (pop),
    .din   ({pend_last, rd_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  assign m_valid = !empty;
  assign m_data  = head[DWIDTH-1:0];
  assign m_last  = !empty && head[DWIDTH];
  assign pop     = m_valid && m_ready;
  assign busy    = (state != IDLE);

  // Occupancy credits a pop this cycle so a full-rate stream keeps flowing.
  assign occ  = {1'b0, cnt} - {2'b0, pop} + {2'b0, pend};
  assign rden = (state == READ) && !full && (occ < 3'(BUF_DEPTH));

  assign fin = ((state == DRAIN) && pop && m_last)
            || ((state == IDLE) && start && (length == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      rdaddr    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= fin;
      pend      <= rden;
      pend_last <= rden && (rem == (AWIDTH+1)'(1));
      unique case (state)
        IDLE: begin
          if (start && (length != '0)) begin
            state  <= READ;
            rem    <= length;
            rdaddr <= base_addr;
          end
        end
        READ: begin
          if (rden) begin
            rdaddr <= rdaddr + AWIDTH'(1);
            rem    <= rem - (AWIDTH+1)'(1);
            if (rem == (AWIDTH+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_READER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= fin;
      if ((state == IDLE) && start) csum <= '0;
      else if (pop)                 csum <= csum ^ m_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader against a queue-based burst model.
// Checksum checks compile in when RAM_READER_CSUM_EN is defined.
module tb_ram_reader;

  localparam int DW    = 16;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, rden, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_data;
`ifdef RAM_READER_CSUM_EN
  logic [DW-1:0] csum;
  logic          csum_valid;
`endif

  ram_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rden      (rden),
    .rdaddr    (rdaddr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
`ifdef RAM_READER_CSUM_EN
    ,
    .csum       (csum),
    .csum_valid (csum_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (rden) rd_data <= mem[rdaddr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // observation state, sampled on the falling edge
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            xfer_c[$];
  int            addr_q[$];
  int issued, xfered, ovf_err, stab_err, done_cnt, done_c;
  int acc_c, first_v, busy_seen, csv_err;
  logic [DW-1:0] csum_d;
  logic          pstall = 1'b0;
  logic [DW-1:0] pdata;
  logic          plast;

  always @(negedge clk) begin
    if (!rst_n) begin
      pstall = 1'b0;
    end else begin
      if (pstall && (!m_valid || m_data !== pdata || m_last !== plast))
        stab_err++;
      pstall = m_valid && !m_ready;
      pdata  = m_data;
      plast  = m_last;
      if (rden) begin
        issued++;
        addr_q.push_back(int'(rdaddr));
      end
      if (m_valid && m_ready) begin
        xfered++;
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        xfer_c.push_back(cyc);
      end
      if (issued - xfered > 2) ovf_err++;
      if (m_valid && first_v < 0) first_v = cyc;
      if (busy) busy_seen++;
      if (done) begin
        done_cnt++;
        done_c = cyc;
      end
      if (start && !busy && acc_c < 0) acc_c = cyc + 1;
`ifdef RAM_READER_CSUM_EN
      if (csum_valid !== done) csv_err++;
      if (done) csum_d = csum;
`endif
    end
  end

  // reference model of one burst
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];
  int            exp_a[$];
  logic [DW-1:0] exp_x;

  task automatic build_exp(input int b, input int n);
    exp_d.delete(); exp_l.delete(); exp_a.delete();
    exp_x = '0;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back((b + i) % DEPTH);
      exp_d.push_back(mem[(b + i) % DEPTH]);
      exp_l.push_back(i == n - 1);
      exp_x = exp_x ^ mem[(b + i) % DEPTH];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_d.delete(); got_l.delete(); xfer_c.delete(); addr_q.delete();
    issued = 0; xfered = 0; ovf_err = 0; stab_err = 0;
    done_cnt = 0; done_c = -1; acc_c = -1; first_v = -1;
    busy_seen = 0; csv_err = 0; csum_d = 'x;
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic burst(input int b, input int n, input int mode, input bit noise);
    clear_mon();
    build_exp(b, n);
    base_addr = AW'(b);
    length    = (AW+1)'(n);
    start     = 1'b1;
    m_ready   = rdy(mode, 0);
    step();
    start = 1'b0;
    for (int k = 1; k < 4 * n + 40; k++) begin
      m_ready = rdy(mode, k);
      if (noise) begin
        start     = m_valid && 1'($urandom_range(0, 1));
        base_addr = AW'($urandom);
        length    = (AW+1)'($urandom);
      end
      step();
      if (done_cnt > 0) break;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    repeat (2) step();
    checks++;
    if ({busy, done, rden, m_valid, m_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000", {busy, done, rden, m_valid, m_last});
    end
    checks++;
    if (rdaddr !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %0h data %0h exp 0 0", rdaddr, m_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    burst(3, 4, 0, 0);
    checks++;
    if (got_d.size() !== 4) begin
      errors++;
      $display("FAIL basic_count got %0d exp 4", got_d.size());
    end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || xfer_c[i] !== xfer_c[0] + i) begin
        errors++;
        $display("FAIL basic_word%0d got %h/%b@%0d exp %h/%b@%0d", i, got_d[i], got_l[i],
                 xfer_c[i], exp_d[i], exp_l[i], xfer_c[0] + i);
      end
    end
    checks++;
    if (first_v - acc_c !== 2) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 2", first_v - acc_c);
    end
    checks++;
    if (done_cnt !== 1 || got_d.size() == 0 || done_c !== xfer_c[$] + 1) begin
      errors++;
      $display("FAIL basic_done got cnt %0d at %0d exp 1 after last xfer", done_cnt, done_c);
    end
  endtask

  task automatic test_wrap();
    burst(126, 4, 0, 0);
    checks++;
    if (addr_q.size() !== 4) begin
      errors++;
      $display("FAIL wrap_reads got %0d exp 4", addr_q.size());
    end
    foreach (exp_d[i]) if (i < got_d.size() && i < addr_q.size()) begin
      checks++;
      if (addr_q[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL wrap_word%0d got a%0d %h/%b exp a%0d %h/%b", i, addr_q[i], got_d[i],
                 got_l[i], exp_a[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    burst(10, 8, 1, 0);
    checks++;
    if (got_d.size() !== 8 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_count got %0d words %0d done exp 8 1", got_d.size(), done_cnt);
    end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL bp_word%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (stab_err !== 0 || ovf_err !== 0) begin
      errors++;
      $display("FAIL bp_rules got stab %0d ovf %0d exp 0 0", stab_err, ovf_err);
    end
  endtask

  task automatic test_zero_length();
    burst(40, 0, 0, 0);
    checks++;
    if (issued !== 0 || first_v !== -1 || busy_seen !== 0) begin
      errors++;
      $display("FAIL zero_quiet got reads %0d valid@%0d busy %0d exp 0 -1 0",
               issued, first_v, busy_seen);
    end
    checks++;
    if (done_cnt !== 1 || done_c !== acc_c) begin
      errors++;
      $display("FAIL zero_done got cnt %0d at %0d exp 1 at %0d", done_cnt, done_c, acc_c);
    end
`ifdef RAM_READER_CSUM_EN
    checks++;
    if (csum_d !== '0 || csv_err !== 0) begin
      errors++;
      $display("FAIL zero_csum got %h err %0d exp 0 0", csum_d, csv_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_mon();
    base_addr = '0;
    length    = (AW+1)'(10);
    start     = 1'b1;
    m_ready   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (xfered >= 3) break;
    end
    checks++;
    if (xfered !== 3) begin
      errors++;
      $display("FAIL rstmid_pre got %0d exp 3", xfered);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rden, m_valid, m_last} !== 5'b0 || rdaddr !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL rstmid_outs got %b %h %h exp 0", {busy, done, rden, m_valid, m_last},
               rdaddr, m_data);
    end
    step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nodone got done %0d busy %b exp 0 0", done_cnt, busy);
    end
    burst(5, 6, 0, 0);
    checks++;
    if (got_d.size() !== 6 || done_cnt !== 1) begin
      errors++;
      $display("FAIL rstmid_after got %0d words %0d done exp 6 1", got_d.size(), done_cnt);
    end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rstmid_word%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_csum();
    mem[20] = 16'hAAAA;
    mem[21] = 16'h5555;
    mem[22] = 16'h00FF;
    burst(20, 3, 2, 0);
    checks++;
    if (got_d.size() !== 3) begin
      errors++;
      $display("FAIL csum_count got %0d exp 3", got_d.size());
    end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL csum_word%0d got %h exp %h", i, got_d[i], exp_d[i]);
      end
    end
`ifdef RAM_READER_CSUM_EN
    checks++;
    if (csum_d !== 16'hFF00 || csv_err !== 0) begin
      errors++;
      $display("FAIL csum_value got %h err %0d exp ff00 0", csum_d, csv_err);
    end
`endif
    for (int k = 20; k < 23; k++) mem[k] = DW'(16'h1000 + k);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int b, n, mode;
      bit noise;
      b     = $urandom_range(0, DEPTH - 1);
      n     = $urandom_range(1, 24);
      mode  = $urandom_range(0, 2);
      noise = 1'($urandom_range(0, 1));
      burst(b, n, mode, noise);
      checks++;
      if (got_d.size() !== n || done_cnt !== 1 || stab_err !== 0 || ovf_err !== 0) begin
        errors++;
        $display("FAIL rand%0d_summary got %0d words %0d done stab %0d ovf %0d exp %0d 1 0 0",
                 t, got_d.size(), done_cnt, stab_err, ovf_err, n);
      end
      foreach (exp_d[i]) if (i < got_d.size()) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d got %h/%b exp %h/%b", t, i, got_d[i], got_l[i],
                   exp_d[i], exp_l[i]);
        end
      end
`ifdef RAM_READER_CSUM_EN
      checks++;
      if (csum_d !== exp_x || csv_err !== 0) begin
        errors++;
        $display("FAIL rand%0d_csum got %h exp %h", t, csum_d, exp_x);
      end
`endif
    end
  endtask

  task automatic test_full_burst();
    int seen [DEPTH];
    int bad;
    burst($urandom_range(0, DEPTH - 1), DEPTH, 2, 0);
    foreach (seen[i]) seen[i] = 0;
    foreach (addr_q[i]) seen[addr_q[i]]++;
    bad = 0;
    foreach (seen[i]) if (seen[i] != 1) bad++;
    checks++;
    if (addr_q.size() !== DEPTH || bad !== 0) begin
      errors++;
      $display("FAIL full_addrs got %0d reads %0d bad exp %0d 0", addr_q.size(), bad, DEPTH);
    end
    checks++;
    if (got_d.size() !== DEPTH || done_cnt !== 1) begin
      errors++;
      $display("FAIL full_count got %0d words %0d done exp %0d 1", got_d.size(), done_cnt, DEPTH);
    end
    bad = 0;
    foreach (exp_d[i]) if (i < got_d.size())
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_words got %0d wrong exp 0", bad);
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(16'h1000 + k);
    clear_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_csum();
    test_reset_mid();
    test_random();
    test_full_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
